dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder on the far end of the CPU load/store path. It accepts word-aligned requests carrying a 4-bit byte-lane write select and lane-positioned write data from the MEM stage. It performs the masked write or the full-word read against an internal word RAM after a programmable number of wait cycles. It returns the raw 32-bit word plus a one-cycle completion pulse, and holds the pipeline with `busy` until then. Byte/halfword extraction and sign extension are done upstream, on the CPU side of the interface.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. The RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 1: extra wait cycles per access. Legal range 0..7.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_en` in 1: access request. Held by the CPU until the cycle `done`=1.
- `select` in 4: byte-lane write enables. Bit i writes bits [8i+7:8i]. 4'b0000 means read.
- `dataaddr` in 32: byte address. Word index is [ADDR_WIDTH+1:2]. Bits [1:0] are ignored.
- `writedata` in 32: lane-positioned store data.
- `readdata` out 32: registered word read. Reset value 0.
- `busy` out 1: stall request to the pipeline. Reset value 0.
- `done` out 1: one-cycle completion pulse. Reset value 0.
- `err` out 1: out-of-range pulse, coincident with `done`. Reset value 0.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - On `req_en`=1, latch `dataaddr`, `select` and `writedata`.
  - Load the wait counter with `LATENCY` and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, counter != 0: decrement the counter and stay in WAIT.
- WAIT, counter == 0: perform the access at this edge, then go to RESP.
  - Write (latched select != 0): write only the enabled lanes of the latched word. Other lanes are unchanged.
  - Read (select == 0): load `readdata` with the addressed word.
  - Out of range (latched addr[31:ADDR_WIDTH+2] != 0): no RAM write, `readdata` is loaded with 0, and `err` is set for the RESP cycle.
- RESP:
  - `done`=1, and `err` as computed.
  - `req_en` is ignored, because it still belongs to the completing instruction.
  - Unconditionally return to IDLE.
- `busy` is combinational: `busy` = (state==IDLE & `req_en`) | (state==WAIT). It is 0 in RESP.
- `readdata` holds its value until the next read or out-of-range access completes. Writes do not change it.
- Inputs that change during WAIT have no effect; only the latched copies are used.
- RAM contents are not reset and are undefined after power-up. `rst` does not clear the RAM.
- Reset mid-operation:
  - State returns to IDLE and `busy`/`done`/`err` go to 0 on the next cycle.
  - A pending write that has not reached its access edge is dropped, with no partial lane writes.
  - `readdata` is reset to 0.

## Timing
- Request sampled in IDLE at cycle t.
- WAIT occupies cycles t+1 .. t+1+LATENCY.
- RAM access happens at the edge that ends cycle t+1+LATENCY.
- RESP occurs at cycle t+2+LATENCY, with `done` high and `readdata` valid.
- End-to-end: `done` asserts LATENCY+2 cycles after the request cycle. LATENCY=0 gives 2 cycles, LATENCY=7 gives 9 cycles.
- `busy` is high from cycle t through t+1+LATENCY, i.e. LATENCY+2 cycles, and low in the `done` cycle.
- Back-to-back: the earliest next request is sampled at cycle t+3+LATENCY, the cycle after RESP.
- `done` and `err` are never high in consecutive cycles.

## Test plan
- **Full-word write then read, LATENCY=1.**
  - Write: `dataaddr`=0x10, `select`=1111, `writedata`=0xDEADBEEF.
  - Read of 0x10 -> `done` 3 cycles after each request, `readdata`=0xDEADBEEF, `busy` high 3 cycles per access.
- **Masked lanes.**
  - Preload word 0x20 with 0x11223344.
  - Write `select`=0100, `writedata`=0x00AA0000, then `select`=0011, `writedata`=0x0000BBCC.
  - Read 0x20 -> 0x11AABBCC.
- **Latency sweep.**
  - LATENCY=0 -> `done` at t+2.
  - LATENCY=7 -> `done` at t+9.
  - `busy` deasserts exactly in the `done` cycle.
- **Out of range, ADDR_WIDTH=10.**
  - Read of 0x00001000 -> `readdata`=0, `err`=1 coincident with `done`.
  - Write of 0x1000 with `select`=1111 -> `err`=1. Word 0x0 is unchanged on read-back.
- **Held request and back-to-back.**
  - `req_en` held high through RESP is not re-accepted: exactly one `done` per instruction.
  - A new request in the cycle after RESP completes normally.
  - Changing `dataaddr` during WAIT does not affect the result.
- **Reset mid-write.**
  - Assert `rst` during WAIT of a write to 0x30 with `select`=1111 and `writedata`=0x55555555.
  - Outputs are 0 the next cycle, and a subsequent read of 0x30 returns the prior contents.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: latches a word-aligned load/store and performs it after LATENCY
// wait cycles. It returns the raw word with a one-cycle done/err pulse and stalls the pipeline via busy.
module dmem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  select,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Handshake: req_en is held by the CPU until the cycle done=1; busy stalls it meanwhile.
  // A request is taken only in IDLE, so req_en still high during RESP is not re-accepted.
  state_t                state, state_nxt;
  logic [2:0]            cnt;
  logic [31:2]           lat_addr;
  logic [3:0]            lat_sel;
  logic [31:0]           lat_wdata;
  logic                  err_q;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] widx;
  logic                  oor;
  logic                  access;
  logic                  unused_bits;

  // Byte offset within the word is irrelevant for word-wide accesses.
  assign unused_bits = ^dataaddr[1:0];

  assign widx   = lat_addr[ADDR_WIDTH+1:2];
  assign oor    = |lat_addr[31:ADDR_WIDTH+2];
  assign access = (state == WAIT) && (cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = req_en;
        if (req_en) state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 3'd0) state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdata  <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_sel   <= '0;
      lat_wdata <= '0;
    end else begin
      if (state == IDLE && req_en) begin
        lat_addr  <= dataaddr[31:2];
        lat_sel   <= select;
        lat_wdata <= writedata;
        cnt       <= 3'(LATENCY);
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (access) begin
        err_q <= oor;
        if (oor)                  readdata <= '0;
        else if (lat_sel == 4'b0) readdata <= mem[widx];
      end
    end
  end

  // RAM is not reset; a reset arriving on the access edge suppresses the write entirely.
  always_ff @(posedge clk) begin
    if (access && !rst && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_sel[i]) mem[widx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 1, 0, 7) share stimulus, gated per target,
// checked against a word-memory model and an expected-response queue.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic [1:0]  tgt;
  logic [3:0]  select;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [2:0][31:0] rd_v;
  logic [2:0]  busy_v, done_v, err_v;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q[$];
  logic [31:0] model[int];
  logic [31:0] last_rd[3];

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_en(req_en && tgt == 2'd0), .select(select),
    .dataaddr(dataaddr), .writedata(writedata), .readdata(rd_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]));

  dmem_resp #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_en(req_en && tgt == 2'd1), .select(select),
    .dataaddr(dataaddr), .writedata(writedata), .readdata(rd_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]));

  dmem_resp #(.ADDR_WIDTH(10), .LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst), .req_en(req_en && tgt == 2'd2), .select(select),
    .dataaddr(dataaddr), .writedata(writedata), .readdata(rd_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]));

  function automatic int lat_of(input int which);
    if (which == 1) return 0;
    if (which == 2) return 7;
    return 1;
  endfunction

  // Drives one request starting #1 after a posedge, holds it through the done cycle,
  // and leaves time at #1 after the edge that ends RESP with req_en dropped.
  task automatic access(input int which, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input bit scramble);
    logic        oor;
    int          key;
    logic [31:0] exp_rd;
    logic [31:0] w;
    logic [32:0] e;
    int          busy_n;
    int          lat;
    bit          seen;
    oor = (addr[31:12] != 20'd0);
    key = which * 4096 + int'(addr[11:2]);
    if (oor)             exp_rd = 32'd0;
    else if (sel == 4'b0) exp_rd = model[key];
    else                 exp_rd = last_rd[which];
    if (!oor && sel != 4'b0) begin
      w = model.exists(key) ? model[key] : 32'hxxxxxxxx;
      for (int i = 0; i < 4; i++) if (sel[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[key] = w;
    end
    last_rd[which] = exp_rd;
    exp_q.push_back({oor, exp_rd});

    tgt = 2'(which); dataaddr = addr; select = sel; writedata = wd; req_en = 1'b1;
    busy_n = 0; lat = -1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done_v[which]) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        if (busy_v[which]) busy_n++;
        tests++;
        if (err_v[which] !== 1'b0) begin
          fails++;
          $display("FAIL err_outside_done inst=%0d cycle=%0d got=%b want=0", which, k, err_v[which]);
        end
        if (scramble && k == 1) begin
          dataaddr = $urandom; select = 4'($urandom); writedata = $urandom;
        end
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout inst=%0d got=no done want=done within 20 cycles", which);
      void'(exp_q.pop_front());
    end else begin
      if (lat !== lat_of(which) + 2) begin
        fails++;
        $display("FAIL done_latency inst=%0d got=%0d want=%0d", which, lat, lat_of(which) + 2);
      end
      tests++;
      if (busy_n !== lat_of(which) + 2) begin
        fails++;
        $display("FAIL busy_cycles inst=%0d got=%0d want=%0d", which, busy_n, lat_of(which) + 2);
      end
      tests++;
      if (busy_v[which] !== 1'b0) begin
        fails++;
        $display("FAIL busy_in_done inst=%0d got=%b want=0", which, busy_v[which]);
      end
      e = exp_q.pop_front();
      tests++;
      if ({err_v[which], rd_v[which]} !== e) begin
        fails++;
        $display("FAIL response inst=%0d addr=%h got err=%b rd=%h want err=%b rd=%h",
                 which, addr, err_v[which], rd_v[which], e[32], e[31:0]);
      end
    end
    @(posedge clk); #1;
    req_en = 1'b0;
  endtask

  // One quiet cycle: no second done, no busy, no err.
  task automatic idle_check(input int which);
    @(negedge clk);
    tests++;
    if ({done_v[which], busy_v[which], err_v[which]} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_done inst=%0d got done/busy/err=%b want=000", which,
               {done_v[which], busy_v[which], err_v[which]});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_en = 1'b0; tgt = 2'd0; select = 4'b0; dataaddr = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({rd_v[i], busy_v[i], done_v[i], err_v[i]} !== 35'd0) begin
        fails++;
        $display("FAIL reset_outputs inst=%0d got rd=%h busy=%b done=%b err=%b want all 0",
                 i, rd_v[i], busy_v[i], done_v[i], err_v[i]);
      end
      last_rd[i] = 32'd0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    access(0, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
    idle_check(0);
    access(0, 32'h10, 4'b0000, 32'h0, 1'b0);
    idle_check(0);
  endtask

  task automatic test_masked_lanes();
    access(0, 32'h20, 4'b1111, 32'h11223344, 1'b0);
    access(0, 32'h20, 4'b0100, 32'h00AA0000, 1'b0);
    access(0, 32'h20, 4'b0011, 32'h0000BBCC, 1'b0);
    access(0, 32'h22, 4'b0000, 32'h0, 1'b0);
    idle_check(0);
  endtask

  task automatic test_latency_sweep();
    for (int w = 1; w <= 2; w++) begin
      access(w, 32'h84, 4'b1111, $urandom, 1'b0);
      idle_check(w);
      access(w, 32'h84, 4'b0000, 32'h0, 1'b0);
      idle_check(w);
    end
  endtask

  task automatic test_out_of_range();
    access(0, 32'h0, 4'b1111, 32'hA5A50F0F, 1'b0);
    access(0, 32'h00001000, 4'b0000, 32'h0, 1'b0);
    idle_check(0);
    access(0, 32'h00001000, 4'b1111, 32'hFFFFFFFF, 1'b0);
    idle_check(0);
    access(0, 32'h0, 4'b0000, 32'h0, 1'b0);
    idle_check(0);
    access(2, 32'h80001004, 4'b0000, 32'h0, 1'b0);
    idle_check(2);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      access(n % 2, 32'h100 + 32'(4 * n), 4'b1111, $urandom, 1'b0);
      access(n % 2, 32'h100 + 32'(4 * n), 4'b0000, 32'h0, n[0]);
    end
    idle_check(1);
    access(0, 32'h200, 4'b1111, 32'h600DF00D, 1'b1);
    access(0, 32'h200, 4'b0000, 32'h0, 1'b1);
    access(1, 32'h204, 4'b0011, 32'h0000_1234, 1'b1);
    access(1, 32'h204, 4'b0000, 32'h0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_reset_mid_write();
    access(0, 32'h30, 4'b1111, 32'hCAFEF00D, 1'b0);
    idle_check(0);
    tgt = 2'd0; dataaddr = 32'h30; select = 4'b1111; writedata = 32'h55555555; req_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req_en = 1'b0;
    @(negedge clk);
    tests++;
    if ({rd_v[0], busy_v[0], done_v[0], err_v[0]} !== 35'd0) begin
      fails++;
      $display("FAIL reset_mid_write_outputs got rd=%h busy=%b done=%b err=%b want all 0",
               rd_v[0], busy_v[0], done_v[0], err_v[0]);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    @(posedge clk); #1;
    idle_check(0);
    access(0, 32'h30, 4'b0000, 32'h0, 1'b0);
    idle_check(0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=still running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_full_word();
    test_masked_lanes();
    test_latency_sweep();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_write();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
